// File: rtl/rv_muldiv_iter.sv
// Iterative radix-2 RV32/64 M-extension unit: shift-add multiply, restoring divide,
// one step per cycle behind a valid/ready request/response handshake.
module rv_muldiv_iter #(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_op1,
    input  logic [XLEN-1:0] req_op2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);
    // state | meaning
    // IDLE  | waiting for a request
    // CALC  | iterating (counter > 0), or finalising sign fix (counter == 0)
    // DONE  | result held on resp_data until consumed
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t state, state_nx;

    logic [2:0]        funct3_q;
    logic              neg_q;
    logic              special_q;
    logic [XLEN-1:0]   opb_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   rem_q;
    logic [CW-1:0]     count_q;
    logic [XLEN-1:0]   result_q;
    logic              resp_valid_q;

    logic              accept;
    logic              abs1_en, abs2_en, s1, s2, neg_in;
    logic [XLEN-1:0]   mag1, mag2;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_res;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, remv, final_res;

    assign req_ready  = (state == S_IDLE) && !flush;
    assign busy       = (state != S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_data  = result_q;
    assign accept     = req_valid && req_ready;

    always_comb begin
        abs1_en = (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                  (req_funct3 == 3'b100) || (req_funct3 == 3'b110);
        abs2_en = (req_funct3 == 3'b001) || (req_funct3 == 3'b100) ||
                  (req_funct3 == 3'b110);
        s1   = abs1_en && req_op1[XLEN-1];
        s2   = abs2_en && req_op2[XLEN-1];
        mag1 = s1 ? -req_op1 : req_op1;
        mag2 = s2 ? -req_op2 : req_op2;
        // A zero divisor keeps the all-ones quotient unsigned-looking, so the slow path matches
        unique case (req_funct3)
            3'b001:  neg_in = s1 ^ s2;
            3'b010:  neg_in = s1;
            3'b100:  neg_in = (s1 ^ s2) && (req_op2 != '0);
            3'b110:  neg_in = s1;
            default: neg_in = 1'b0;
        endcase
        div_zero = req_funct3[2] && (req_op2 == '0);
        div_ovf  = req_funct3[2] && !req_funct3[0] &&
                   (req_op1 == MOST_NEG) && (req_op2 == '1);
        special  = FAST_SPECIAL && (div_zero || div_ovf);
        if (div_zero)
            special_res = req_funct3[1] ? req_op1 : '1;
        else
            special_res = req_funct3[1] ? '0 : MOST_NEG;
    end

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {rem_q, acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_ge    = !div_diff[XLEN];
        prod      = neg_q ? -acc_q : acc_q;
        quot      = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        remv      = neg_q ? -rem_q : rem_q;
        unique case (funct3_q)
            3'b000:                 final_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quot;
            default:                final_res = remv;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (accept) state_nx = S_CALC;
            S_CALC:  if (count_q == '0) state_nx = S_DONE;
            S_DONE:  if (resp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            funct3_q     <= '0;
            neg_q        <= 1'b0;
            special_q    <= 1'b0;
            opb_q        <= '0;
            acc_q        <= '0;
            rem_q        <= '0;
            count_q      <= '0;
            result_q     <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                S_IDLE: if (accept) begin
                    funct3_q  <= req_funct3;
                    neg_q     <= neg_in;
                    special_q <= special;
                    opb_q     <= req_funct3[2] ? mag2 : mag1;
                    acc_q     <= {{XLEN{1'b0}}, (req_funct3[2] ? mag1 : mag2)};
                    rem_q     <= '0;
                    // Special cases skip iteration: one finalising CALC cycle, then DONE
                    count_q   <= special ? '0 : CW'(XLEN);
                    if (special) result_q <= special_res;
                end
                S_CALC: begin
                    if (count_q != '0) begin
                        count_q <= count_q - CW'(1);
                        if (funct3_q[2]) begin
                            rem_q            <= div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
                            acc_q[XLEN-1:0] <= {acc_q[XLEN-2:0], div_ge};
                        end else begin
                            acc_q <= {mul_sum, acc_q[XLEN-1:1]};
                        end
                    end else begin
                        if (!special_q) result_q <= final_res;
                        resp_valid_q <= 1'b1;
                    end
                end
                S_DONE: if (resp_ready) resp_valid_q <= 1'b0;
                default: ;
            endcase
            if (flush) resp_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rv_muldiv_iter.sv
// Bench for rv_muldiv_iter: directed and random ops against a 64-bit arithmetic
// reference, plus stall, flush and mid-operation reset scenarios.
module tb_rv_muldiv_iter;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        resp_ready = 1'b1;
    logic        use_slow = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_op1 = '0;
    logic [31:0] req_op2 = '0;

    logic        req_valid_f, req_valid_s;
    logic        req_ready_f, resp_valid_f, busy_f;
    logic        req_ready_s, resp_valid_s, busy_s;
    logic [31:0] resp_data_f, resp_data_s;
    logic        cur_ready, cur_valid, cur_busy;
    logic [31:0] cur_data;

    int errors = 0;
    int checks = 0;

    assign req_valid_f = req_valid && !use_slow;
    assign req_valid_s = req_valid && use_slow;
    assign cur_ready   = use_slow ? req_ready_s  : req_ready_f;
    assign cur_valid   = use_slow ? resp_valid_s : resp_valid_f;
    assign cur_busy    = use_slow ? busy_s       : busy_f;
    assign cur_data    = use_slow ? resp_data_s  : resp_data_f;

    always #5 clock = ~clock;

    rv_muldiv_iter #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .req_valid(req_valid_f), .req_ready(req_ready_f), .req_funct3(req_funct3),
        .req_op1(req_op1), .req_op2(req_op2),
        .resp_valid(resp_valid_f), .resp_ready(resp_ready), .resp_data(resp_data_f),
        .busy(busy_f)
    );

    rv_muldiv_iter #(.XLEN(32), .FAST_SPECIAL(1'b0)) dut_slow (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .req_valid(req_valid_s), .req_ready(req_ready_s), .req_funct3(req_funct3),
        .req_op1(req_op1), .req_op2(req_op2),
        .resp_valid(resp_valid_s), .resp_ready(resp_ready), .resp_data(resp_data_s),
        .busy(busy_s)
    );

    // RISC-V M semantics computed with 64-bit integer arithmetic
    function automatic logic [31:0] ref_model(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        longint      sa, sb, ub, r;
        logic [63:0] w;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (f)
            3'd0: begin r = sa * sb; w = r; return w[31:0]; end
            3'd1: begin r = sa * sb; w = r; return w[63:32]; end
            3'd2: begin r = sa * ub; w = r; return w[63:32]; end
            3'd3: begin w = {32'b0, a} * {32'b0, b}; return w[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
                r = sa / sb; w = r; return w[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == 32'hFFFF_FFFF) return 32'h0;
                r = sa % sb; w = r; return w[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        return f[2] && (b == 0 || (!f[0] && a == MIN && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return MIN;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] data, output int lat);
        int guard;
        guard = 0;
        @(negedge clock);
        while (!cur_ready && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        req_funct3 = f; req_op1 = a; req_op2 = b; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clock); #1;
            lat++;
        end while (!cur_valid && lat < 100);
        data = cur_data;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        checks++; if (resp_valid_f !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid_f); end
        checks++; if (resp_data_f !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h expected 00000000", resp_data_f); end
        checks++; if (busy_f !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_f); end
        checks++; if (req_ready_f !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready_f); end
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[14] = '{
        '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33},
        '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33},
        '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33},
        '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33},
        '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33},
        '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33},
        '{3'd5, 32'd100,        32'd7,         32'd14,        33},
        '{3'd7, 32'd100,        32'd7,         32'd2,         33},
        '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1},
        '{3'd6, 32'd5,          32'd0,         32'd5,         1},
        '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1},
        '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1},
        '{3'd5, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 1},
        '{3'd7, 32'h1234_5678,  32'd0,         32'h1234_5678, 1}
    };

    task automatic test_directed();
        logic [31:0] d;
        int          lat;
        use_slow = 1'b0;
        foreach (vecs[i]) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, d, lat);
            checks++;
            if (d !== vecs[i].exp) begin
                errors++;
                $display("FAIL directed_data[%0d] f=%0d: got %h expected %h", i, vecs[i].f, d, vecs[i].exp);
            end
            checks++;
            if (lat != vecs[i].lat) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, vecs[i].lat);
            end
        end
    endtask

    task automatic test_slow_special();
        logic [31:0] d;
        int          lat;
        use_slow = 1'b1;
        for (int i = 8; i < 14; i++) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, d, lat);
            checks++;
            if (d !== vecs[i].exp) begin
                errors++;
                $display("FAIL slow_special_data[%0d]: got %h expected %h", i, d, vecs[i].exp);
            end
            checks++;
            if (lat != 33) begin
                errors++;
                $display("FAIL slow_special_latency[%0d]: got %0d expected 33", i, lat);
            end
        end
        use_slow = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b, d, e;
        int          lat, exp_lat;
        use_slow = 1'b0;
        for (int n = 0; n < 80; n++) begin
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            e = ref_model(f, a, b);
            exp_lat = is_special(f, a, b) ? 1 : 33;
            run_op(f, a, b, d, lat);
            checks++;
            if (d !== e) begin
                errors++;
                $display("FAIL random_data f=%0d a=%h b=%h: got %h expected %h", f, a, b, d, e);
            end
            checks++;
            if (lat != exp_lat) begin
                errors++;
                $display("FAIL random_latency f=%0d: got %0d expected %0d", f, lat, exp_lat);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] e, d;
        int          lat;
        bit          stable;
        use_slow = 1'b0;
        e = ref_model(3'd5, 32'd1000, 32'd9);
        resp_ready = 1'b0;
        @(negedge clock);
        req_funct3 = 3'd5; req_op1 = 32'd1000; req_op2 = 32'd9; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clock); #1;
            lat++;
        end while (!cur_valid && lat < 100);
        checks++;
        if (cur_data !== e) begin errors++; $display("FAIL stall_data: got %h expected %h", cur_data, e); end
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (cur_valid !== 1'b1 || cur_data !== e || cur_ready !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (!stable) begin errors++; $display("FAIL stall_hold: valid=%b data=%h ready=%b expected 1 %h 0", cur_valid, cur_data, cur_ready, e); end
        @(negedge clock);
        resp_ready = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (cur_valid !== 1'b0 || cur_busy !== 1'b0 || cur_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: valid=%b busy=%b ready=%b expected 0 0 1", cur_valid, cur_busy, cur_ready);
        end
        run_op(3'd0, 32'd12, 32'd11, d, lat);
        checks++;
        if (d !== 32'd132) begin errors++; $display("FAIL stall_next_op: got %h expected %h", d, 32'd132); end
    endtask

    task automatic test_flush();
        bit seen;
        use_slow = 1'b0;
        @(negedge clock);
        req_funct3 = 3'd0; req_op1 = 32'd3; req_op2 = 32'd5; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        #1;
        checks++;
        if (cur_ready !== 1'b0) begin errors++; $display("FAIL flush_ready_calc: got %b expected 0", cur_ready); end
        @(posedge clock); #1;
        checks++;
        if (cur_busy !== 1'b0 || cur_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_abort: busy=%b valid=%b expected 0 0", cur_busy, cur_valid);
        end
        @(negedge clock);
        flush = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clock); #1;
            if (cur_valid || cur_busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL flush_no_resp: got activity expected none"); end
        @(negedge clock);
        flush = 1'b1;
        #1;
        checks++;
        if (cur_ready !== 1'b0) begin errors++; $display("FAIL flush_ready_idle: got %b expected 0", cur_ready); end
        @(negedge clock);
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int          lat;
        bit          seen;
        use_slow = 1'b0;
        @(negedge clock);
        req_funct3 = 3'd4; req_op1 = 32'd77; req_op2 = 32'd6; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++;
        if (cur_busy !== 1'b0 || cur_valid !== 1'b0 || cur_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b valid=%b data=%h expected 0 0 00000000", cur_busy, cur_valid, cur_data);
        end
        @(negedge clock);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clock); #1;
            if (cur_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL reset_mid_no_resp: got resp_valid expected none"); end
        run_op(3'd6, 32'hFFFF_FF9C, 32'd7, d, lat);
        checks++;
        if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL reset_recover: got %h expected fffffffe", d); end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        #1;
        test_reset();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        test_reset();
        test_directed();
        test_slow_special();
        test_random();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
